// File: rtl/updown_count_sequencer.sv
// Command-driven up/down/ping-pong count sequencer with repeat count and hold.
// Optional abort input compiled in when UPDOWN_SEQ_ABORT_EN is defined.
module updown_count_sequencer #(
  parameter int WIDTH = 4,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             hold,
`ifdef UPDOWN_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] out,
  output logic             up_down,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [1:0]       MODE_DOWN = 2'b01;
  localparam logic [1:0]       MODE_PP   = 2'b10;
  localparam logic [1:0]       MODE_RSV  = 2'b11;
  localparam logic [WIDTH-1:0] OUT_ONE   = WIDTH'(1);
  localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             up_down_q, up_down_d;
  logic             busy_q, busy_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             abort_req;
  logic             at_end;

`ifdef UPDOWN_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // End of the current direction's travel: L when rising, 0 when falling.
  assign at_end = up_down_q ? (out_q == limit_q) : (out_q == '0);

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    mode_d    = mode_q;
    limit_d   = limit_q;
    rem_d     = rem_q;
    out_d     = out_q;
    up_down_d = up_down_q;
    wrap_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mode_d  = cmd_mode;
          limit_d = cmd_limit;
          rem_d   = cmd_reps;
          if (cmd_mode == MODE_RSV) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (cmd_mode == MODE_DOWN) begin
            state_d   = S_RUN;
            out_d     = cmd_limit;
            up_down_d = 1'b0;
          end else begin
            state_d   = S_RUN;
            out_d     = '0;
            up_down_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (abort_req) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (!hold) begin
          if (!at_end) begin
            out_d = up_down_q ? (out_q + OUT_ONE) : (out_q - OUT_ONE);
          end else if (mode_q == MODE_PP && up_down_q && limit_q != '0) begin
            // Ping-pong turnaround at the top; L itself is shown only once.
            up_down_d = 1'b0;
            out_d     = limit_q - OUT_ONE;
          end else if (rem_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            rem_d  = rem_q - REP_ONE;
            wrap_d = 1'b1;
            out_d  = (mode_q == MODE_DOWN) ? limit_q : '0;
            if (mode_q == MODE_PP) up_down_d = 1'b1;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      limit_q   <= '0;
      rem_q     <= '0;
      out_q     <= '0;
      up_down_q <= 1'b1;
      busy_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_d;
      mode_q    <= mode_d;
      limit_q   <= limit_d;
      rem_q     <= rem_d;
      out_q     <= out_d;
      up_down_q <= up_down_d;
      busy_q    <= busy_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign out       = out_q;
  assign up_down   = up_down_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Randomized self-checking bench: expected per-cycle count values are built from
// the pass structure (ramp/sweep lists repeated reps+1 times) and replayed against the DUT.
module tb_updown_count_sequencer;

  localparam int WIDTH = 4;
  localparam int REP_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [WIDTH-1:0] cmd_limit;
  logic [REP_W-1:0] cmd_reps;
  logic             hold;
`ifdef UPDOWN_SEQ_ABORT_EN
  logic             abort;
`endif
  logic [WIDTH-1:0] out;
  logic             up_down;
  logic             busy;
  logic             wrap;
  logic             done;
  logic             err;

  int checks   = 0;
  int failures = 0;

  int exp_out[$];
  bit exp_ud[$];
  bit exp_wr[$];
  int prev_out;
  bit prev_ud;

  always #5 clk = ~clk;

  updown_count_sequencer #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_limit (cmd_limit),
    .cmd_reps  (cmd_reps),
    .hold      (hold),
`ifdef UPDOWN_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .out       (out),
    .up_down   (up_down),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected visible sequence: one entry per un-held RUN cycle.
  function automatic void build(input logic [1:0] mode, input int lim, input int reps);
    exp_out.delete();
    exp_ud.delete();
    exp_wr.delete();
    for (int p = 0; p <= reps; p++) begin
      if (mode == 2'b00) begin
        for (int v = 0; v <= lim; v++) begin
          exp_out.push_back(v); exp_ud.push_back(1'b1); exp_wr.push_back(p > 0 && v == 0);
        end
      end else if (mode == 2'b01) begin
        for (int v = lim; v >= 0; v--) begin
          exp_out.push_back(v); exp_ud.push_back(1'b0); exp_wr.push_back(p > 0 && v == lim);
        end
      end else begin
        for (int k = 0; k <= 2 * lim; k++) begin
          exp_out.push_back(k <= lim ? k : 2 * lim - k);
          exp_ud.push_back(k <= lim);
          exp_wr.push_back(p > 0 && k == 0);
        end
      end
    end
  endfunction

  // hold_kind: 0 none, 1 random, 2 three cycles at index 5. cut_at: index to reset/abort at (-1 none).
  task automatic run_cmd(input logic [1:0] mode, input int lim, input int reps,
                         input int hold_kind, input int cut_at, input bit cut_rst);
    int  i;
    int  guard;
    int  held;
    int  last;
    bit  stepped;
    build(mode, lim, reps);
    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_limit = lim[WIDTH-1:0];
    cmd_reps  = reps[REP_W-1:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    if (mode == 2'b11) begin
      check("rsv_done", done, 1);
      check("rsv_err", err, 1);
      check("rsv_busy", busy, 0);
      check("rsv_out", out, prev_out);
      check("rsv_ud", up_down, prev_ud);
      @(negedge clk);
      check("rsv_done_clr", done, 0);
      check("rsv_ready", cmd_ready, 1);
      return;
    end
    i = 0; guard = 0; held = 0; stepped = 1'b1;
    while (i < exp_out.size()) begin
      check("run_out", out, exp_out[i]);
      check("run_ud", up_down, exp_ud[i]);
      check("run_wrap", wrap, stepped && exp_wr[i]);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_ready", cmd_ready, 0);
      if (i == cut_at) begin
        cmd_valid = 1'b0;
        if (cut_rst) begin
          hold = 1'b0;
          rst  = 1'b1;
          @(negedge clk);
          check("rst_out", out, 0);
          check("rst_ud", up_down, 1);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          check("rst_ready", cmd_ready, 0);
          rst = 1'b0;
          @(negedge clk);
          check("rst_ready_back", cmd_ready, 1);
          check("rst_done_after", done, 0);
          prev_out = 0;
          prev_ud  = 1'b1;
          return;
        end
`ifdef UPDOWN_SEQ_ABORT_EN
        else begin
          hold  = 1'b1;
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          hold  = 1'b0;
          check("abort_done", done, 1);
          check("abort_err", err, 1);
          check("abort_busy", busy, 0);
          check("abort_out", out, exp_out[i]);
          @(negedge clk);
          check("abort_done_clr", done, 0);
          check("abort_ready", cmd_ready, 1);
          prev_out = exp_out[i];
          prev_ud  = exp_ud[i];
          return;
        end
`endif
      end
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_mode  = 2'($urandom_range(0, 3));
      case (hold_kind)
        1:       hold = ($urandom_range(0, 3) == 0);
        2:       hold = (i == 5 && held < 3);
        default: hold = 1'b0;
      endcase
      if (hold) held++;
      @(negedge clk);
      stepped = !hold;
      if (!hold) i++;
      guard++;
      if (guard > 8 * exp_out.size() + 16) begin
        check("run_bound", i, exp_out.size());
        return;
      end
    end
    hold = 1'b0;
    cmd_valid = 1'b0;
    last = exp_out.size() - 1;
    check("fin_done", done, 1);
    check("fin_err", err, 0);
    check("fin_busy", busy, 0);
    check("fin_wrap", wrap, 0);
    check("fin_out", out, exp_out[last]);
    check("fin_ud", up_down, exp_ud[last]);
    if (hold_kind == 2) check("hold_total", guard, exp_out.size() + 3);
    prev_out = exp_out[last];
    prev_ud  = exp_ud[last];
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_ready", cmd_ready, 1);
    check("idle_out", out, prev_out);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = '0;
    cmd_limit = '0;
    cmd_reps  = '0;
    hold      = 1'b0;
`ifdef UPDOWN_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_ready", cmd_ready, 0);
    check("reset_out", out, 0);
    check("reset_ud", up_down, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wrap", wrap, 0);
    check("reset_err", err, 0);
    rst = 1'b0;
    prev_out = 0;
    prev_ud  = 1'b1;

    run_cmd(2'b00, 3, 0, 0, -1, 1'b0);
    run_cmd(2'b01, 2, 1, 0, -1, 1'b0);
    run_cmd(2'b10, 2, 1, 0, -1, 1'b0);
    run_cmd(2'b00, 9, 0, 2, -1, 1'b0);
    run_cmd(2'b11, 5, 0, 0, -1, 1'b0);
    run_cmd(2'b00, 0, 2, 0, -1, 1'b0);
    run_cmd(2'b10, 0, 2, 0, -1, 1'b0);
    run_cmd(2'b00, 15, 1, 0, -1, 1'b0);
    run_cmd(2'b01, 15, 0, 1, -1, 1'b0);
    run_cmd(2'b10, 7, 0, 0, 4, 1'b1);
`ifdef UPDOWN_SEQ_ABORT_EN
    run_cmd(2'b00, 9, 0, 0, 3, 1'b0);
`endif

    for (int n = 0; n < 25; n++) begin
      int m;
      m = $urandom_range(0, 7);
      run_cmd(m >= 6 ? 2'b11 : 2'(m % 3), $urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 1), -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
